// File: rtl/logic_pod_edge_encoder_if.sv
`default_nettype none
// ============================================================================
// logic_pod_edge_encoder_if : sample input and record output bundle for the pod encoder
// rev 1.0
// ============================================================================
interface logic_pod_edge_encoder_if #(
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = 48
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic                 capture_en;
   logic [7:0][19:0]     samples;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_kind;
   logic [TS_WIDTH-1:0]  out_timestamp;
   logic [15:0]          out_idle;
   logic [7:0][19:0]     out_samples;
   logic                 overflow;
   logic                 overflow_clear;
   logic [LW-1:0]        fifo_level;

   // master: sampling datapath plus record consumer; slave: the encoder
   modport master (
      output capture_en, samples, out_ready, overflow_clear,
      input  out_valid, out_kind, out_timestamp, out_idle, out_samples, overflow, fifo_level
   );

   modport slave (
      input  capture_en, samples, out_ready, overflow_clear,
      output out_valid, out_kind, out_timestamp, out_idle, out_samples, overflow, fifo_level
   );
endinterface
`default_nettype wire

// File: rtl/logic_pod_edge_encoder.sv
`default_nettype none
// ============================================================================
// logic_pod_edge_encoder : collapses idle 8x20-sample blocks, queues timestamped records
// rev 1.0
// ============================================================================
module logic_pod_edge_encoder #(
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = 48
) (
   input  logic                    clk_250mhz,
   input  logic                    rst,
   logic_pod_edge_encoder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = 1 + TS_WIDTH + 16 + 160;

   logic [TS_WIDTH-1:0] ts_q;
   logic                s1_en_q;
   logic [7:0][19:0]    s1_samples_q;
   logic [TS_WIDTH-1:0] s1_ts_q;

   logic [7:0]          last_q, last_d;
   logic [15:0]         idle_q, idle_d;
   logic                force_q, force_d;
   logic                ovf_q, ovf_d;
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]       level_q, level_d;
   logic [RW-1:0]       mem_q [FIFO_DEPTH];

   logic [7:0]          lane_chg;
   logic                changed;
   logic                full;
   logic                pop;
   logic                push;
   logic                drop;
   logic                wr_req;
   logic                wr_kind;
   logic [RW-1:0]       wr_data;
   logic [RW-1:0]       head;

   // Input stage: the block is tagged with the counter value of the cycle it arrived in
   always_ff @(posedge clk_250mhz) begin
      if (rst) begin
         ts_q         <= '0;
         s1_en_q      <= 1'b0;
         s1_samples_q <= '0;
         s1_ts_q      <= '0;
      end else begin
         ts_q         <= ts_q + TS_WIDTH'(1);
         s1_en_q      <= bus.capture_en;
         s1_samples_q <= bus.samples;
         s1_ts_q      <= ts_q;
      end
   end

   always_comb begin
      lane_chg = '0;
      for (int g = 0; g < 8; g++) begin
         lane_chg[g] = (s1_samples_q[g][19:1] != s1_samples_q[g][18:0]) ||
                       (s1_samples_q[g][0] != last_q[g]);
      end
   end

   assign changed = |lane_chg;
   assign full    = (level_q == LW'(FIFO_DEPTH));
   assign pop     = (level_q != '0) && bus.out_ready;

   always_comb begin
      last_d  = last_q;
      idle_d  = idle_q;
      force_d = force_q;
      wr_req  = 1'b0;
      wr_kind = 1'b0;
      push    = 1'b0;
      drop    = 1'b0;
      if (s1_en_q) begin
         for (int g = 0; g < 8; g++) begin
            last_d[g] = s1_samples_q[g][19];
         end
         if (changed || force_q) begin
            wr_req  = 1'b1;
            wr_kind = 1'b1;
         end else if (idle_q == 16'hFFFF) begin
            wr_req  = 1'b1;
         end else begin
            idle_d = idle_q + 16'd1;
         end
         if (wr_req) begin
            idle_d = '0;
            // fullness is taken before this cycle's pop, so a full FIFO always drops
            if (full) begin
               drop    = 1'b1;
               force_d = 1'b1;
            end else begin
               push = 1'b1;
               if (wr_kind) force_d = 1'b0;
            end
         end
      end else begin
         idle_d  = '0;
         force_d = 1'b1;
      end
   end

   assign ovf_d   = drop ? 1'b1 : (bus.overflow_clear ? 1'b0 : ovf_q);
   assign level_d = level_q + LW'(push) - LW'(pop);
   assign wr_data = {wr_kind, s1_ts_q, idle_q, s1_samples_q};

   always_ff @(posedge clk_250mhz) begin
      if (rst) begin
         last_q   <= '0;
         idle_q   <= '0;
         force_q  <= 1'b1;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         last_q   <= last_d;
         idle_q   <= idle_d;
         force_q  <= force_d;
         ovf_q    <= ovf_d;
         level_q  <= level_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk_250mhz) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   // Storage is not reset, so the head is masked to zero while the FIFO is empty
   assign bus.out_valid = (level_q != '0);
   assign head          = bus.out_valid ? mem_q[rd_ptr_q] : '0;
   assign {bus.out_kind, bus.out_timestamp, bus.out_idle, bus.out_samples} = head;
   assign bus.overflow   = ovf_q;
   assign bus.fifo_level = level_q;
endmodule
`default_nettype wire

// File: tb/tb_logic_pod_edge_encoder.sv
`default_nettype none
// ============================================================================
// tb_logic_pod_edge_encoder : scenario tasks checked against a record-level reference model
// rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_logic_pod_edge_encoder;
   localparam int DEPTH = 16;
   localparam int TSW   = 48;

   typedef struct packed {
      logic             kind;
      logic [TSW-1:0]   ts;
      logic [15:0]      idle;
      logic [7:0][19:0] samp;
   } rec_t;

   logic clk_250mhz = 1'b0;
   logic rst        = 1'b1;
   always #2 clk_250mhz = ~clk_250mhz;

   logic_pod_edge_encoder_if #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) bus ();

   logic_pod_edge_encoder #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
      .clk_250mhz (clk_250mhz),
      .rst        (rst),
      .bus        (bus)
   );

   rec_t             mq[$];
   rec_t             m_popped[$];
   rec_t             obs[$];
   logic [7:0]       m_last;
   int               m_idle;
   bit               m_force;
   bit               m_ovf;
   logic [TSW-1:0]   m_ts;
   bit               p_en;
   logic [7:0][19:0] p_samp;
   logic [TSW-1:0]   p_ts;
   int               n_cmp = 0;
   int               n_err = 0;

   // Applies the encoding rules to the block presented one cycle earlier
   task automatic model_edge();
      bit   full, pop, chg, wr, drop, prev;
      rec_t r;
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_idle = 0; m_force = 1; m_last = '0;
         p_en = 0; p_samp = '0; p_ts = '0; m_ts = '0;
         return;
      end
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && bus.out_ready;
      drop = 0;
      if (pop) m_popped.push_back(mq.pop_front());
      if (p_en) begin
         chg = 0;
         for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 20; i++) begin
               if (i == 0) prev = m_last[g];
               else        prev = p_samp[g][i-1];
               if (p_samp[g][i] !== prev) chg = 1;
            end
         end
         r.samp = p_samp; r.ts = p_ts; r.kind = 0; r.idle = '0; wr = 0;
         if (chg || m_force) begin
            wr = 1; r.kind = 1; r.idle = m_idle[15:0];
         end else if (m_idle == 65535) begin
            wr = 1; r.kind = 0; r.idle = 16'hFFFF;
         end else begin
            m_idle++;
         end
         for (int g = 0; g < 8; g++) m_last[g] = p_samp[g][19];
         if (wr) begin
            m_idle = 0;
            if (full) begin
               drop = 1; m_force = 1;
            end else begin
               mq.push_back(r);
               if (r.kind) m_force = 0;
            end
         end
      end else begin
         m_idle = 0; m_force = 1;
      end
      if (drop) m_ovf = 1;
      else if (bus.overflow_clear) m_ovf = 0;
      p_en = bus.capture_en; p_samp = bus.samples; p_ts = m_ts; m_ts = m_ts + 1'b1;
   endtask

   task automatic tick();
      rec_t r;
      if (bus.out_valid && bus.out_ready) begin
         r = {bus.out_kind, bus.out_timestamp, bus.out_idle, bus.out_samples};
         obs.push_back(r);
      end
      model_edge();
      @(posedge clk_250mhz);
      #1;
   endtask

   function automatic logic [7:0][19:0] rand_blk();
      logic [7:0][19:0] b;
      for (int g = 0; g < 8; g++) b[g] = 20'($urandom);
      b[0][1:0] = 2'b10;
      return b;
   endfunction

   function automatic logic [7:0][19:0] hold_blk(input logic [7:0][19:0] prev);
      logic [7:0][19:0] b;
      for (int g = 0; g < 8; g++) b[g] = {20{prev[g][19]}};
      return b;
   endfunction

   task automatic test_reset();
      rst = 1; bus.capture_en = 0; bus.out_ready = 0; bus.overflow_clear = 0;
      bus.samples = rand_blk();
      repeat (3) tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
      n_cmp++; if (bus.fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
      n_cmp++; if (bus.out_kind !== 1'b0) begin n_err++; $display("FAIL reset_kind: got %b want 0", bus.out_kind); end
      n_cmp++; if (bus.out_timestamp !== '0) begin n_err++; $display("FAIL reset_ts: got %h want 0", bus.out_timestamp); end
      n_cmp++; if (bus.out_idle !== 16'd0) begin n_err++; $display("FAIL reset_idle: got %h want 0", bus.out_idle); end
      n_cmp++; if (bus.out_samples !== '0) begin n_err++; $display("FAIL reset_samples: got %h want 0", bus.out_samples); end
      rst = 0;
   endtask

   task automatic test_idle_run();
      logic [TSW-1:0] t1, t6;
      obs.delete(); m_popped.delete();
      bus.out_ready = 1; bus.capture_en = 1;
      for (int b = 1; b <= 6; b++) begin
         bus.samples = '0;
         if (b == 6) bus.samples[3] = 20'hFFF80;
         if (b == 1) t1 = m_ts;
         if (b == 6) t6 = m_ts;
         tick();
      end
      bus.samples = '0; bus.samples[3] = 20'hFFFFF;
      repeat (4) tick();
      n_cmp++; if (obs.size() !== 2) begin n_err++; $display("FAIL idle_count: got %0d want 2", obs.size()); end
      if (obs.size() == 2) begin
         n_cmp++; if (obs[0] !== {1'b1, t1, 16'd0, 160'd0}) begin n_err++; $display("FAIL idle_ref: got %h want ts %h idle 0", obs[0], t1); end
         n_cmp++; if (obs[1].kind !== 1'b1 || obs[1].idle !== 16'd4 || obs[1].ts !== t6) begin n_err++; $display("FAIL idle_run: got kind %b idle %0d ts %h want 1 4 %h", obs[1].kind, obs[1].idle, obs[1].ts, t6); end
         n_cmp++; if (obs[1].samp[3] !== 20'hFFF80) begin n_err++; $display("FAIL idle_samp: got %h want fff80", obs[1].samp[3]); end
      end
   endtask

   task automatic test_boundary();
      logic [TSW-1:0] tb;
      obs.delete(); m_popped.delete();
      bus.samples = '0; bus.samples[3] = 20'hFFFFF; bus.samples[0] = 20'hFFFFF;
      tick();
      bus.samples[0] = 20'h00000; tb = m_ts;
      tick();
      repeat (4) tick();
      n_cmp++; if (obs.size() !== 2) begin n_err++; $display("FAIL bound_count: got %0d want 2", obs.size()); end
      if (obs.size() == 2) begin
         n_cmp++; if (obs[1].kind !== 1'b1 || obs[1].ts !== tb || obs[1].samp[0] !== 20'h0 || obs[1].idle !== 16'd0) begin n_err++; $display("FAIL bound_b: got kind %b ts %h lane0 %h want 1 %h 0", obs[1].kind, obs[1].ts, obs[1].samp[0], tb); end
      end
   endtask

   task automatic test_keepalive();
      logic [TSW-1:0] tr;
      obs.delete(); m_popped.delete();
      bus.capture_en = 0;
      tick();
      bus.capture_en = 1; tr = m_ts;
      repeat (65540) tick();
      bus.samples = {8{20'hFFFFF}};
      repeat (4) tick();
      n_cmp++; if (obs.size() !== 3) begin n_err++; $display("FAIL ka_count: got %0d want 3", obs.size()); end
      if (obs.size() == 3) begin
         n_cmp++; if (obs[0].kind !== 1'b1 || obs[0].ts !== tr || obs[0].idle !== 16'd0) begin n_err++; $display("FAIL ka_ref: got kind %b ts %h idle %0d want 1 %h 0", obs[0].kind, obs[0].ts, obs[0].idle, tr); end
         n_cmp++; if (obs[1].kind !== 1'b0 || obs[1].idle !== 16'hFFFF || obs[1].ts !== tr + 48'd65536) begin n_err++; $display("FAIL ka_rec: got kind %b idle %h ts %h want 0 ffff %h", obs[1].kind, obs[1].idle, obs[1].ts, tr + 48'd65536); end
         n_cmp++; if (obs[2].kind !== 1'b1 || obs[2].idle !== 16'd3 || obs[2].ts !== tr + 48'd65540) begin n_err++; $display("FAIL ka_restart: got kind %b idle %0d ts %h want 1 3 %h", obs[2].kind, obs[2].idle, obs[2].ts, tr + 48'd65540); end
      end
   endtask

   task automatic test_overflow();
      logic [TSW-1:0] t0;
      obs.delete(); m_popped.delete();
      bus.out_ready = 0; bus.capture_en = 1; t0 = m_ts;
      repeat (20) begin bus.samples = rand_blk(); tick(); end
      bus.capture_en = 0;
      repeat (3) tick();
      n_cmp++; if (bus.fifo_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", bus.fifo_level); end
      n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
      bus.overflow_clear = 1; tick(); bus.overflow_clear = 0;
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
      bus.out_ready = 1; bus.capture_en = 1; bus.samples = '0;
      repeat (24) tick();
      n_cmp++; if (obs.size() !== 17) begin n_err++; $display("FAIL ovf_count: got %0d want 17", obs.size()); end
      if (obs.size() == 17) begin
         for (int i = 0; i < 16; i++) begin
            n_cmp++; if (obs[i].ts !== t0 + TSW'(i)) begin n_err++; $display("FAIL ovf_order[%0d]: got ts %h want %h", i, obs[i].ts, t0 + TSW'(i)); end
         end
         n_cmp++; if (obs[16].kind !== 1'b1 || obs[16].idle !== 16'd0 || obs[16].samp !== '0) begin n_err++; $display("FAIL ovf_forced: got kind %b idle %0d want 1 0", obs[16].kind, obs[16].idle); end
      end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_after: got %b want 0", bus.overflow); end
   endtask

   task automatic test_back_to_back();
      rec_t hold;
      bit   held;
      obs.delete(); m_popped.delete();
      bus.capture_en = 1;
      for (int c = 0; c < 400; c++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) bus.samples = hold_blk(bus.samples);
         else                           bus.samples = rand_blk();
         held = bus.out_valid && !bus.out_ready;
         hold = {bus.out_kind, bus.out_timestamp, bus.out_idle, bus.out_samples};
         tick();
         if (held) begin
            n_cmp++; if (!bus.out_valid || {bus.out_kind, bus.out_timestamp, bus.out_idle, bus.out_samples} !== hold) begin n_err++; $display("FAIL bp_stable@%0d: got valid %b ts %h want valid 1 ts %h", c, bus.out_valid, bus.out_timestamp, hold.ts); end
         end
         n_cmp++; if (bus.fifo_level !== 5'(mq.size()) || bus.out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL bp_level@%0d: got %0d/%b want %0d", c, bus.fifo_level, bus.out_valid, mq.size()); end
         n_cmp++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL bp_ovf@%0d: got %b want %b", c, bus.overflow, m_ovf); end
      end
      bus.out_ready = 1; bus.capture_en = 0;
      repeat (DEPTH + 4) tick();
      n_cmp++; if (obs.size() !== m_popped.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", obs.size(), m_popped.size()); end
      for (int i = 0; i < obs.size() && i < m_popped.size(); i++) begin
         n_cmp++; if (obs[i] !== m_popped[i]) begin n_err++; $display("FAIL bp_rec[%0d]: got %h want %h", i, obs[i], m_popped[i]); end
         if (i > 0) begin
            n_cmp++; if (obs[i].ts <= obs[i-1].ts) begin n_err++; $display("FAIL bp_ts_order[%0d]: got %h after %h", i, obs[i].ts, obs[i-1].ts); end
         end
      end
      bus.overflow_clear = 1; tick(); bus.overflow_clear = 0;
   endtask

   task automatic test_reset_enable();
      bus.out_ready = 0; bus.capture_en = 1;
      repeat (3) begin bus.samples = rand_blk(); tick(); end
      bus.capture_en = 0;
      tick();
      n_cmp++; if (bus.fifo_level !== 5'd3) begin n_err++; $display("FAIL re_queued: got %0d want 3", bus.fifo_level); end
      rst = 1; bus.capture_en = 1; bus.samples = rand_blk();
      tick();
      rst = 0; bus.capture_en = 0;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 5'd0) begin n_err++; $display("FAIL re_flush: got valid %b level %0d want 0 0", bus.out_valid, bus.fifo_level); end
      obs.delete(); m_popped.delete();
      bus.out_ready = 1; bus.capture_en = 1; bus.samples = '0;
      repeat (5) tick();
      bus.capture_en = 0;
      repeat (10) tick();
      bus.capture_en = 1;
      repeat (6) tick();
      n_cmp++; if (obs.size() !== 2) begin n_err++; $display("FAIL re_count: got %0d want 2", obs.size()); end
      if (obs.size() == 2) begin
         n_cmp++; if (obs[1].kind !== 1'b1 || obs[1].idle !== 16'd0) begin n_err++; $display("FAIL re_gap: got kind %b idle %0d want 1 0", obs[1].kind, obs[1].idle); end
      end
      for (int i = 0; i < obs.size() && i < m_popped.size(); i++) begin
         n_cmp++; if (obs[i] !== m_popped[i]) begin n_err++; $display("FAIL re_rec[%0d]: got %h want %h", i, obs[i], m_popped[i]); end
      end
   endtask

   initial begin
      bus.capture_en = 0; bus.out_ready = 0; bus.overflow_clear = 0; bus.samples = '0;
      m_last = '0; m_idle = 0; m_force = 1; m_ovf = 0; m_ts = '0;
      p_en = 0; p_samp = '0; p_ts = '0;
      test_reset();
      test_idle_run();
      test_boundary();
      test_keepalive();
      test_overflow();
      test_back_to_back();
      test_reset_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/logic_pod_edge_encoder.md
# logic_pod_edge_encoder

Change-detecting block encoder for one 8-lane logic analyzer pod, directly downstream of the pod's 5 Gsps sampling datapath. Each 250 MHz cycle it receives 20 samples per lane. Blocks that contain no transitions are collapsed into an idle-run count. Blocks with activity are emitted as timestamped records into an internal FIFO with a valid/ready output. Capture memory and trigger logic consume the records.

## Interface
Parameters:
- FIFO_DEPTH, 16: record FIFO depth; must be a power of two, at least 4.
- TS_WIDTH, 48: timestamp counter width.

Ports:
- clk_250mhz, in, 1: sole clock.
- rst, in, 1: reset; synchronous, active-high.
- capture_en, in, 1: encoding enable.
- samples, in, la_sample_t[7:0]: one block of samples.
  - Each lane is 20 bits; bit 0 is the oldest sample, bit 19 the newest.
- out_valid, out, 1: FIFO head record valid.
- out_ready, in, 1: consumer accepts the head record.
- out_kind, out, 1: record type; 1 = DATA, 0 = KEEPALIVE.
- out_timestamp, out, TS_WIDTH: cycle count of the block.
- out_idle, out, 16: number of idle blocks immediately preceding this block.
- out_samples, out, la_sample_t[7:0]: raw block.
- overflow, out, 1: sticky flag; a record was dropped.
- overflow_clear, in, 1: clears overflow.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Timestamp counter:
  - Free-running, increments every cycle.
  - Wraps modulo 2^TS_WIDTH.
  - Reset value 0.
- Per-lane reference `last[g]` holds bit 19 of the previous enabled block.
- A block is CHANGED if either condition holds:
  - any lane has samples[g][i] != samples[g][i-1] for some i in 1..19, or
  - any lane has samples[g][0] != last[g].
- force flag:
  - Set by reset, by capture_en being low, and by any dropped record.
  - While set, the next enabled block is treated as CHANGED (it becomes the reference point).
  - Cleared when that block's record is written.
- Per enabled block:
  - CHANGED or force: write a DATA record with out_idle = idle_cnt, then set idle_cnt = 0.
  - Unchanged and idle_cnt == 16'hFFFF: write a KEEPALIVE record with out_idle = 16'hFFFF, then set idle_cnt = 0.
  - Otherwise: idle_cnt += 1; nothing is written.
- Every written record carries the block's own samples and its own timestamp.
- `last` updates on every enabled block, including blocks whose record is dropped.
- capture_en low:
  - No records are written.
  - idle_cnt is held at 0 and force is set.
  - Already-queued records still drain.
- FIFO full:
  - Fullness is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if out_ready pops that cycle.
  - A drop sets overflow, sets force, and sets idle_cnt = 0.
- overflow:
  - Cleared by overflow_clear.
  - If a drop and overflow_clear occur in the same cycle, set wins.
- Output handshake:
  - The head record pops on the rising edge where out_valid && out_ready.
  - out_* fields stay stable while out_valid && !out_ready.
  - out_valid never deasserts without a pop.
- Reset mid-operation:
  - FIFO is flushed and the pipeline is cleared.
  - No record for any block presented during rst high is ever output.

## Timing
- Reset values:
  - out_valid = 0, overflow = 0, fifo_level = 0.
  - out_kind, out_timestamp, out_idle, out_samples = 0.
  - Timestamp counter = 0, idle_cnt = 0, last = 0, force = 1.
- Input pipeline:
  - samples and capture_en are registered on the edge ending cycle k.
  - Change detection and the FIFO write occur on the edge ending cycle k+1.
- Latency:
  - With an empty FIFO, out_valid = 1 during cycle k+2.
  - out_timestamp = counter value in cycle k.
- Throughput:
  - The FIFO accepts at most one write and one read per cycle.
  - A sustained write of one record per cycle is supported while out_ready stays high.
- fifo_level updates on the same edge as the push or pop. A simultaneous push and pop leaves it unchanged.

## Test plan
1. Reference and idle run:
   - Stimulus: release reset, capture_en = 1, all lanes constant 0 for 5 blocks, then lane 3 toggles at bit 7 in block 6.
   - Response: DATA record at ts of block 1 with idle 0, then DATA record for block 6 with idle 4.
2. Boundary transition:
   - Stimulus: block A has lane 0 = 20'hFFFFF, next block B has lane 0 = 20'h00000.
   - Response: B is emitted as DATA, detected through the last[] comparison.
3. Keepalive:
   - Stimulus: 65537 unchanged blocks after the reference block.
   - Response: one KEEPALIVE with idle 16'hFFFF at block 65537, idle_cnt restarts at 0.
4. Overflow:
   - Stimulus: out_ready = 0, 20 consecutive changing blocks, FIFO_DEPTH 16.
   - Response: exactly 16 records queued and overflow = 1.
   - Then pulse overflow_clear; overflow = 0. Set out_ready = 1; the 16 records drain in order, and the next block is a forced DATA.
5. Backpressure stability:
   - Stimulus: toggle out_ready randomly at 50% with continuous changing input.
   - Response: no field changes while out_valid && !out_ready, no duplicated records, and timestamps strictly increasing.
6. Reset and enable:
   - Stimulus: assert rst for 1 cycle with 3 records queued; separately drop capture_en for 10 cycles.
   - Response: after reset, out_valid = 0 in the next cycle. After the enable gap, the first block is DATA with idle 0.
